pipe_hazard_ctrl: RTL and testbench

- Central hazard controller for the 5-stage RISC-V pipeline.
- Generates per-stage stall (hold) and flush (bubble) controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Handles three hazard classes:
  - load-use (data hazard);
  - taken branch/jump resolved in EX (control hazard);
  - multi-cycle data-memory wait (structural hazard).
- Keeps stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central hazard controller for a 5-stage RISC-V pipeline.
// Produces same-cycle (Mealy) stall/flush controls for the PC and the
// IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles load-use
// data hazards, taken branches resolved in EX and multi-cycle data-memory
// waits. It also keeps saturating stall/flush counters and a sticky memory
// timeout flag.
//
// Ports
//   clk, rst                   clock (rising edge), async active-high reset
//   id_rs1/2, id_rs1/2_used    source registers of the ID instruction
//   ex_rd, ex_read_en, ex_wb_en  destination / load / writeback of the EX instruction
//   ex_branch_taken            taken branch/jump resolved in EX
//   mem_req, mem_ready         data-memory access and completion in MEM
//   pc_stall .. memwb_flush    pipeline hold/bubble controls
//   mem_timeout                sticky: a memory wait reached MEM_TIMEOUT cycles
//   stall_cnt, flush_cnt       saturating performance counters
module pipe_hazard_ctrl #(
  parameter int unsigned LU_CYCLES   = 1,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_read_en,
  input  logic             ex_wb_en,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_LU_STALL = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_e;

  localparam logic [3:0]  LU_INIT = 4'(LU_CYCLES - 1);
  localparam logic [15:0] WAIT_MAX = 16'(MEM_TIMEOUT);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  state_e           eff_state;
  logic [3:0]       lu_left_q, lu_left_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic lu_hit, mem_wait;
  logic pc_stall_c, ifid_stall_c, ifid_flush_c, idex_stall_c;
  logic idex_flush_c, exmem_stall_c, memwb_flush_c;

  assign lu_hit = ex_read_en & ex_wb_en & (ex_rd != 5'd0) &
                  ((id_rs1_used & (id_rs1 == ex_rd)) |
                   (id_rs2_used & (id_rs2 == ex_rd)));
  assign mem_wait = mem_req & ~mem_ready;

  // Once a memory wait ends, the cycle is handled as if the state were
  // ret_state, so a pending load-use stall resumes without a dead cycle.
  assign eff_state = (state_q == S_MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    lu_left_d     = lu_left_q;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_stall_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_stall_c = 1'b0;
    memwb_flush_c = 1'b0;

    if (mem_wait) begin
      pc_stall_c    = 1'b1;
      ifid_stall_c  = 1'b1;
      idex_stall_c  = 1'b1;
      exmem_stall_c = 1'b1;
      memwb_flush_c = 1'b1;
      if (state_q != S_MEM_WAIT) begin
        ret_d   = state_q;
        state_d = S_MEM_WAIT;
      end
    end else if (ex_branch_taken) begin
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
      state_d      = S_RUN;
      lu_left_d    = '0;
    end else if (eff_state == S_LU_STALL) begin
      pc_stall_c   = 1'b1;
      ifid_stall_c = 1'b1;
      idex_flush_c = 1'b1;
      if (lu_left_q <= 4'd1) begin
        state_d   = S_RUN;
        lu_left_d = '0;
      end else begin
        state_d   = S_LU_STALL;
        lu_left_d = lu_left_q - 4'd1;
      end
    end else if (lu_hit) begin
      pc_stall_c   = 1'b1;
      ifid_stall_c = 1'b1;
      idex_flush_c = 1'b1;
      if (LU_CYCLES > 1) begin
        state_d   = S_LU_STALL;
        lu_left_d = LU_INIT;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      state_d = S_RUN;
    end
  end

  // Counts consecutive wait cycles, saturating; the flag is set on the edge
  // where the count reaches the limit.
  always_comb begin
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    if (mem_wait) begin
      wait_cnt_d = (wait_cnt_q >= WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 16'd1;
      if (wait_cnt_d == WAIT_MAX) begin
        mem_timeout_d = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (ex_branch_taken && !mem_wait && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_RUN;
      ret_q         <= S_RUN;
      lu_left_q     <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      lu_left_q     <= lu_left_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  // Controls are forced low while reset is held, whatever the inputs.
  assign pc_stall    = pc_stall_c    & ~rst;
  assign ifid_stall  = ifid_stall_c  & ~rst;
  assign ifid_flush  = ifid_flush_c  & ~rst;
  assign idex_stall  = idex_stall_c  & ~rst;
  assign idex_flush  = idex_flush_c  & ~rst;
  assign exmem_stall = exmem_stall_c & ~rst;
  assign memwb_flush = memwb_flush_c & ~rst;
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LU_CYCLES=1 and 3) share inputs
// and are checked every cycle against a behavioural model, plus directed
// scenarios with literal expectations.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MT   = 8;
  localparam int unsigned CW   = 6;
  localparam int          CMAX = (1 << CW) - 1;

  // control vector order: {pc, ifid_s, ifid_f, idex_s, idex_f, exmem_s, memwb_f}
  localparam logic [6:0] C_MW   = 7'b1101011;
  localparam logic [6:0] C_BR   = 7'b0010100;
  localparam logic [6:0] C_LU   = 7'b1100100;
  localparam logic [6:0] C_NONE = 7'b0000000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic ex_read_en = 1'b0, ex_wb_en = 1'b0, ex_branch_taken = 1'b0;
  logic mem_req = 1'b0, mem_ready = 1'b0;

  logic pc_a, ifs_a, iff_a, ids_a, idf_a, exs_a, mwf_a, to_a;
  logic pc_b, ifs_b, iff_b, ids_b, idf_b, exs_b, mwf_b, to_b;
  logic [CW-1:0] sc_a, fc_a, sc_b, fc_b;
  logic [6:0] ctl_a, ctl_b;

  assign ctl_a = {pc_a, ifs_a, iff_a, ids_a, idf_a, exs_a, mwf_a};
  assign ctl_b = {pc_b, ifs_b, iff_b, ids_b, idf_b, exs_b, mwf_b};

  pipe_hazard_ctrl #(.LU_CYCLES(1), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_read_en(ex_read_en), .ex_wb_en(ex_wb_en),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_stall(pc_a), .ifid_stall(ifs_a),
    .ifid_flush(iff_a), .idex_stall(ids_a), .idex_flush(idf_a),
    .exmem_stall(exs_a), .memwb_flush(mwf_a), .mem_timeout(to_a),
    .stall_cnt(sc_a), .flush_cnt(fc_a));

  pipe_hazard_ctrl #(.LU_CYCLES(3), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
    .ex_read_en(ex_read_en), .ex_wb_en(ex_wb_en),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .pc_stall(pc_b), .ifid_stall(ifs_b),
    .ifid_flush(iff_b), .idex_stall(ids_b), .idex_flush(idf_b),
    .exmem_stall(exs_b), .memwb_flush(mwf_b), .mem_timeout(to_b),
    .stall_cnt(sc_b), .flush_cnt(fc_b));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining bubbles, run length of the current wait,
  // sticky timeout and the two event counters, per instance.
  int lu_cfg[2] = '{1, 3};
  int m_rem[2], m_wrun[2], m_sc[2], m_fc[2];
  bit m_to[2];

  always @(negedge clk) begin
    bit mw, lh;
    logic [6:0] exp_ctl, act_ctl;
    int act_sc, act_fc, act_to;
    mw = mem_req && !mem_ready;
    lh = ex_read_en && ex_wb_en && (ex_rd != 0) &&
         ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_rem[k] = 0; m_wrun[k] = 0; m_sc[k] = 0; m_fc[k] = 0; m_to[k] = 0;
        exp_ctl = C_NONE;
      end else if (mw)                      exp_ctl = C_MW;
      else if (ex_branch_taken)             exp_ctl = C_BR;
      else if (m_rem[k] > 0 || lh)          exp_ctl = C_LU;
      else                                  exp_ctl = C_NONE;

      act_ctl = (k == 0) ? ctl_a : ctl_b;
      act_sc  = (k == 0) ? int'(sc_a) : int'(sc_b);
      act_fc  = (k == 0) ? int'(fc_a) : int'(fc_b);
      act_to  = (k == 0) ? int'(to_a) : int'(to_b);
      check($sformatf("model_ctl[%0d]", k), int'(act_ctl), int'(exp_ctl));
      check($sformatf("model_stall_cnt[%0d]", k), act_sc, m_sc[k]);
      check($sformatf("model_flush_cnt[%0d]", k), act_fc, m_fc[k]);
      check($sformatf("model_timeout[%0d]", k), act_to, int'(m_to[k]));

      if (!rst) begin
        if (exp_ctl[6] && m_sc[k] < CMAX) m_sc[k]++;
        if (mw) begin
          m_wrun[k]++;
          if (m_wrun[k] >= MT) m_to[k] = 1;
        end else begin
          m_wrun[k] = 0;
          if (ex_branch_taken) begin
            m_rem[k] = 0;
            if (m_fc[k] < CMAX) m_fc[k]++;
          end else if (m_rem[k] > 0) begin
            m_rem[k]--;
          end else if (lh) begin
            m_rem[k] = lu_cfg[k] - 1;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = '0; ex_read_en = 1'b0; ex_wb_en = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic load_use_x5();
    idle();
    ex_rd = 5'd5; ex_read_en = 1'b1; ex_wb_en = 1'b1;
    id_rs1 = 5'd5; id_rs1_used = 1'b1;
  endtask

  task automatic reset_pulse();
    cyc(); rst = 1'b1; idle();
    cyc(); rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;

    cyc(); idle(); #1;
    check("reset_ctl", int'(ctl_a), 0);
    check("reset_stall_cnt", int'(sc_a), 0);

    // Load-use with LU_CYCLES=1: exactly one bubble.
    cyc(); load_use_x5(); #1;
    check("lu_ctl", int'(ctl_a), int'(C_LU));
    cyc(); idle(); #1;
    check("lu_one_cycle", int'(ctl_a), 0);
    check("lu_stall_cnt", int'(sc_a), 1);

    // x0 destination and unused source never hazard.
    cyc(); load_use_x5(); ex_rd = 5'd0; id_rs1 = 5'd0; #1;
    check("lu_x0", int'(ctl_a), 0);
    cyc(); load_use_x5(); id_rs1_used = 1'b0; id_rs2 = 5'd5; #1;
    check("lu_unused", int'(ctl_a), 0);

    // Branch wins over a simultaneous load-use.
    cyc(); load_use_x5(); ex_branch_taken = 1'b1; #1;
    check("br_ctl", int'(ctl_a), int'(C_BR));
    check("br_ctl_b", int'(ctl_b), int'(C_BR));
    cyc(); idle(); #1;
    check("br_after", int'(ctl_a), 0);
    check("br_flush_cnt", int'(fc_a), 1);
    check("br_no_stall", int'(sc_a), 1);

    // Four-cycle memory wait.
    for (int i = 0; i < 4; i++) begin
      cyc(); idle(); mem_req = 1'b1; #1;
      check("mw_ctl", int'(ctl_a), int'(C_MW));
    end
    cyc(); mem_ready = 1'b1; #1;
    check("mw_done", int'(ctl_a), 0);
    check("mw_stall_cnt", int'(sc_a), 5);
    check("mw_no_timeout", int'(to_a), 0);

    // Nested: LU_CYCLES=3 instance, wait inside the load-use stall.
    reset_pulse();
    cyc(); load_use_x5(); #1;
    check("nest_lu", int'(ctl_b), int'(C_LU));
    for (int i = 0; i < 2; i++) begin
      cyc(); idle(); mem_req = 1'b1; #1;
      check("nest_mw", int'(ctl_b), int'(C_MW));
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); idle(); #1;
      check("nest_bubble", int'(ctl_b), int'(C_LU));
    end
    cyc(); idle(); #1;
    check("nest_done", int'(ctl_b), 0);
    check("nest_stall_cnt", int'(sc_b), 5);

    // Timeout after 8 consecutive wait cycles, sticky afterwards.
    for (int i = 1; i <= 10; i++) begin
      cyc(); idle(); mem_req = 1'b1; #1;
      check($sformatf("to_wait%0d", i), int'(to_a), (i > 8) ? 1 : 0);
    end
    cyc(); mem_ready = 1'b1; #1;
    check("to_sticky", int'(to_a), 1);
    cyc(); idle(); #1;
    check("to_sticky_idle", int'(to_a), 1);

    // Asynchronous reset in the middle of a memory wait.
    cyc(); idle(); mem_req = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("arst_ctl", int'(ctl_a), 0);
    check("arst_stall_cnt", int'(sc_a), 0);
    check("arst_timeout", int'(to_a), 0);
    cyc(); rst = 1'b0; idle();
    cyc(); #1;
    check("arst_after", int'(ctl_a), 0);
    check("arst_after_cnt", int'(sc_a), 0);

    // Randomized traffic, small register range so hazards are frequent.
    for (int n = 0; n < 4000; n++) begin
      cyc();
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      id_rs1_used     = 1'($urandom_range(0, 1));
      id_rs2_used     = 1'($urandom_range(0, 1));
      ex_rd           = 5'($urandom_range(0, 3));
      ex_read_en      = 1'($urandom_range(0, 1));
      ex_wb_en        = ($urandom_range(0, 3) != 0);
      ex_branch_taken = ($urandom_range(0, 7) == 0);
      mem_req         = ($urandom_range(0, 2) == 0);
      mem_ready       = ($urandom_range(0, 2) == 0);
    end

    cyc(); idle();
    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
